// File: rtl/mmr_bus_ctrl.sv
// mmr_bus_ctrl: valid/ready bus slave for MSIP/MTIMECMP/MTIME with one-cycle write strobes
// and a tear-free MTIME read via a hi-half snapshot taken on the lo-half read.
module mmr_bus_ctrl #(
    parameter int          RSZ          = 32,
    parameter logic [31:0] MMR_BASE     = 32'h0200_0000,
    parameter logic [31:0] MSIP_OFS     = 32'h0000_0000,
    parameter logic [31:0] MTIMECMP_OFS = 32'h0000_4000,
    parameter logic [31:0] MTIME_OFS    = 32'h0000_BFF8
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [31:0]      req_addr,
    input  logic [RSZ-1:0]   req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RSZ-1:0]   rsp_rdata,
    output logic             rsp_err,
    output logic             mtime_lo_wr,
    output logic             mtime_hi_wr,
    output logic             mtimecmp_lo_wr,
    output logic             mtimecmp_hi_wr,
    output logic             msip_wr,
    output logic [RSZ-1:0]   mmr_wr_data,
    input  logic [2*RSZ-1:0] mtime,
    input  logic [2*RSZ-1:0] mtimecmp,
    input  logic [RSZ-1:0]   msip_reg
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic [2:0] {T_MSIP, T_CMP_LO, T_CMP_HI, T_TIME_LO, T_TIME_HI, T_ERR} tgt_t;

    state_t         state, state_nx;
    tgt_t           tgt, tgt_dec;
    logic           wr;
    logic [RSZ-1:0] wdata;
    logic           snap_vld;
    logic [RSZ-1:0] shadow_hi;
    logic [RSZ-1:0] rd_mux;

    always_comb begin
        tgt_dec = T_ERR;
        if (req_addr[1:0] == 2'b00) begin
            if (req_addr == MMR_BASE + MSIP_OFS) tgt_dec = T_MSIP;
            else if (req_addr == MMR_BASE + MTIMECMP_OFS) tgt_dec = T_CMP_LO;
            else if (req_addr == MMR_BASE + MTIMECMP_OFS + 32'd4) tgt_dec = T_CMP_HI;
            else if (req_addr == MMR_BASE + MTIME_OFS) tgt_dec = T_TIME_LO;
            else if (req_addr == MMR_BASE + MTIME_OFS + 32'd4) tgt_dec = T_TIME_HI;
        end
    end

    // MTIME hi reads prefer the snapshot so a lo/hi pair cannot tear across a carry
    always_comb begin
        rd_mux = (wr || tgt == T_ERR) ? '0 :
                 tgt == T_MSIP    ? msip_reg :
                 tgt == T_CMP_LO  ? mtimecmp[RSZ-1:0] :
                 tgt == T_CMP_HI  ? mtimecmp[2*RSZ-1:RSZ] :
                 tgt == T_TIME_LO ? mtime[RSZ-1:0] :
                 snap_vld         ? shadow_hi : mtime[2*RSZ-1:RSZ];
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        msip_wr        = 1'b0;
        mtimecmp_lo_wr = 1'b0;
        mtimecmp_hi_wr = 1'b0;
        mtime_lo_wr    = 1'b0;
        mtime_hi_wr    = 1'b0;
        mmr_wr_data    = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                state_nx  = req_valid ? EXEC : IDLE;
            end
            EXEC: begin
                state_nx       = RESP;
                msip_wr        = wr && tgt == T_MSIP;
                mtimecmp_lo_wr = wr && tgt == T_CMP_LO;
                mtimecmp_hi_wr = wr && tgt == T_CMP_HI;
                mtime_lo_wr    = wr && tgt == T_TIME_LO;
                mtime_hi_wr    = wr && tgt == T_TIME_HI;
                mmr_wr_data    = (wr && tgt != T_ERR) ? wdata : '0;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nx  = rsp_ready ? IDLE : RESP;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            tgt       <= T_ERR;
            wr        <= 1'b0;
            wdata     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            snap_vld  <= 1'b0;
            shadow_hi <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                tgt   <= tgt_dec;
                wr    <= req_wr;
                wdata <= req_wdata;
            end
            if (state == EXEC) begin
                rsp_rdata <= rd_mux;
                rsp_err   <= tgt == T_ERR;
                snap_vld  <= !wr && tgt == T_TIME_LO;
                if (!wr && tgt == T_TIME_LO) shadow_hi <= mtime[2*RSZ-1:RSZ];
            end
        end
    end
endmodule

// File: tb/tb_mmr_bus_ctrl.sv
// tb_mmr_bus_ctrl: scoreboard bench for mmr_bus_ctrl against a transaction-level register model.
module tb_mmr_bus_ctrl;
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mtime_lo_wr, mtime_hi_wr, mtimecmp_lo_wr, mtimecmp_hi_wr, msip_wr;
    logic [31:0] mmr_wr_data;
    logic [63:0] mtime = '0;
    logic [63:0] mtimecmp = '0;
    logic [31:0] msip_reg = '0;

    mmr_bus_ctrl dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mtime_lo_wr(mtime_lo_wr), .mtime_hi_wr(mtime_hi_wr),
        .mtimecmp_lo_wr(mtimecmp_lo_wr), .mtimecmp_hi_wr(mtimecmp_hi_wr), .msip_wr(msip_wr),
        .mmr_wr_data(mmr_wr_data), .mtime(mtime), .mtimecmp(mtimecmp), .msip_reg(msip_reg)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { logic [31:0] d; logic e; int c; } rsp_t;
    typedef struct { logic [4:0] m; logic [31:0] d; int c; } stb_t;
    rsp_t rq[$];
    stb_t sq[$];

    int vecs = 0, miss = 0, cyc = 0, rr_mode = 0;
    logic        snap_v = 1'b0;
    logic [31:0] snap_d = '0;
    // strobe bit order: {mtime_lo, mtime_hi, mtimecmp_lo, mtimecmp_hi, msip}
    logic [4:0]  msk [6] = '{5'b00001, 5'b00100, 5'b00010, 5'b10000, 5'b01000, 5'b00000};

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(posedge clk_in) begin
        #1;
        rsp_ready = rr_mode == 1 ? 1'b0 : rr_mode == 2 ? 1'b1 : ($urandom_range(0, 2) != 0);
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        vecs++;
        if (a !== x) begin
            miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", n, a, x, cyc);
        end
    endtask

    task automatic fail(input string n);
        vecs++;
        miss++;
        $display("FAIL %s (cycle %0d)", n, cyc);
    endtask

    function automatic int tgt_of(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        if (a[1:0] != 2'b00) return 5;
        case (o)
            32'h0000_0000: return 0;
            32'h0000_4000: return 1;
            32'h0000_4004: return 2;
            32'h0000_BFF8: return 3;
            32'h0000_BFFC: return 4;
            default:       return 5;
        endcase
    endfunction

    // Issues one request; expectations are queued at acceptance, and the task returns
    // only after the EXEC edge so callers may change the live registers afterwards.
    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic rst_exec, output int acc);
        int t;
        logic [31:0] rd;
        rsp_t r;
        stb_t s;
        t = tgt_of(a);
        rd = (w || t == 5) ? 32'h0 :
             t == 0 ? msip_reg : t == 1 ? mtimecmp[31:0] : t == 2 ? mtimecmp[63:32] :
             t == 3 ? mtime[31:0] : snap_v ? snap_d : mtime[63:32];
        if (!w && t == 3) snap_d = mtime[63:32];
        snap_v = !w && t == 3;
        req_valid = 1'b1; req_wr = w; req_addr = a; req_wdata = d;
        acc = -1;
        for (int i = 0; i < 300; i++) begin
            if (req_ready) begin
                @(posedge clk_in); #1;
                acc = cyc;
                break;
            end
            @(posedge clk_in); #1;
        end
        req_valid = 1'b0;
        if (acc < 0) begin
            fail("accept_timeout");
            return;
        end
        r.d = rd; r.e = t == 5; r.c = acc + 1;
        rq.push_back(r);
        if (w && t != 5) begin
            s.m = msk[t]; s.d = d; s.c = acc;
            sq.push_back(s);
        end
        if (rst_exec) begin
            reset_in = 1'b1;
            void'(rq.pop_back());
            if (w && t != 5) void'(sq.pop_back());
            snap_v = 1'b0; snap_d = '0;
        end
        @(posedge clk_in); #1;
        if (rst_exec) begin
            reset_in = 1'b0;
            chk("rst_exec_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_exec_strobes", 64'({mtime_lo_wr, mtime_hi_wr, mtimecmp_lo_wr, mtimecmp_hi_wr, msip_wr}), 64'd0);
            chk("rst_exec_req_ready", 64'(req_ready), 64'd1);
        end
    endtask

    task automatic wait_idle(input int n);
        int k;
        k = 0;
        while ((!req_ready || rq.size() != 0) && k < 300) begin
            @(posedge clk_in); #1;
            k++;
        end
        if (k >= 300) fail("idle_timeout");
        repeat (n) begin @(posedge clk_in); #1; end
    endtask

    logic        in_rsp = 1'b0;
    int          first_c = 0;
    logic [31:0] held_d = '0;
    logic        held_e = 1'b0;
    rsp_t        mr;
    stb_t        ms;
    logic [4:0]  sv;

    always @(negedge clk_in) begin
        if (reset_in) in_rsp = 1'b0;
        else if (rsp_valid) begin
            if (!in_rsp) begin
                in_rsp = 1'b1; first_c = cyc; held_d = rsp_rdata; held_e = rsp_err;
            end else chk("rsp_stable", 64'({rsp_rdata, rsp_err}), 64'({held_d, held_e}));
            if (rsp_ready) begin
                if (rq.size() == 0) fail("rsp_unexpected");
                else begin
                    mr = rq.pop_front();
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(mr.d));
                    chk("rsp_err", 64'(rsp_err), 64'(mr.e));
                    chk("rsp_latency", 64'(first_c), 64'(mr.c));
                end
                in_rsp = 1'b0;
            end
        end
    end

    always @(negedge clk_in) begin
        sv = {mtime_lo_wr, mtime_hi_wr, mtimecmp_lo_wr, mtimecmp_hi_wr, msip_wr};
        if (!reset_in && sv != 5'b0) begin
            if (sq.size() == 0) fail("strobe_unexpected");
            else begin
                ms = sq.pop_front();
                chk("strobe_mask", 64'(sv), 64'(ms.m));
                chk("strobe_data", 64'(mmr_wr_data), 64'(ms.d));
                chk("strobe_cycle", 64'(cyc), 64'(ms.c));
            end
        end
        if (!reset_in && (req_ready || rsp_valid)) chk("wr_data_idle", 64'(mmr_wr_data), 64'd0);
    end

    int a0, a1;
    logic [31:0] adr [10] = '{BASE, BASE + 32'h4000, BASE + 32'h4004, BASE + 32'hBFF8, BASE + 32'hBFFC,
                              BASE + 32'h2, BASE + 32'h8000, BASE + 32'h4, BASE + 32'hC000, 32'h0300_4000};

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        chk("reset_strobes", 64'({mtime_lo_wr, mtime_hi_wr, mtimecmp_lo_wr, mtimecmp_hi_wr, msip_wr}), 64'd0);
        chk("reset_wr_data", 64'(mmr_wr_data), 64'd0);
        reset_in = 1'b0;
        msip_reg = 32'h1; mtimecmp = 64'hAAAA_5555_1234_8765;
        do_txn(1'b1, BASE + 32'h4000, 32'h0000_1234, 1'b0, a0);
        wait_idle(1);
        mtime = 64'h0000_0001_FFFF_FFFE;
        do_txn(1'b0, BASE + 32'hBFF8, 32'h0, 1'b0, a0);
        wait_idle(5);
        mtime = 64'h0000_0002_0000_0003;
        do_txn(1'b0, BASE + 32'hBFFC, 32'h0, 1'b0, a0);
        wait_idle(1);
        do_txn(1'b0, BASE + 32'hBFF8, 32'h0, 1'b0, a0);
        do_txn(1'b0, BASE, 32'h0, 1'b0, a0);
        mtime = 64'h0000_0005_0000_0000;
        do_txn(1'b0, BASE + 32'hBFFC, 32'h0, 1'b0, a0);
        do_txn(1'b0, BASE + 32'h2, 32'h0, 1'b0, a0);
        do_txn(1'b0, BASE + 32'h8000, 32'h0, 1'b0, a0);
        do_txn(1'b1, BASE + 32'h2, 32'hDEAD_BEEF, 1'b0, a0);
        do_txn(1'b1, BASE + 32'h8000, 32'hCAFE_F00D, 1'b0, a0);
        wait_idle(1);
        rr_mode = 1;
        @(posedge clk_in); #1;
        do_txn(1'b0, BASE + 32'h4004, 32'h0, 1'b0, a0);
        fork
            do_txn(1'b1, BASE, 32'h0000_0001, 1'b0, a1);
            begin
                repeat (4) begin
                    @(negedge clk_in);
                    chk("stall_req_ready", 64'(req_ready), 64'd0);
                    chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
                end
                rr_mode = 2;
            end
        join
        chk("accept_after_handshake", 64'(a1), 64'(a0 + 7));
        rr_mode = 0;
        wait_idle(1);
        do_txn(1'b1, BASE + 32'hBFFC, 32'h0000_0077, 1'b1, a0);
        repeat (5) begin @(posedge clk_in); #1; end
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) mtime = {$urandom, $urandom};
            else mtime = mtime + 64'($urandom_range(0, 5));
            if ($urandom_range(0, 7) == 0) mtimecmp = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) msip_reg = $urandom;
            do_txn(1'($urandom_range(0, 2) == 0),
                   $urandom_range(0, 11) == 11 ? $urandom : adr[$urandom_range(0, 9)],
                   $urandom, 1'b0, a0);
            if ($urandom_range(0, 4) == 0) wait_idle($urandom_range(0, 3));
        end
        wait_idle(3);
        chk("rsp_queue_drained", 64'(rq.size()), 64'd0);
        chk("strobe_queue_drained", 64'(sq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
